corr_dump_collector: RTL

- Hardware replacement for the software accumulation-interrupt handler; sits downstream of simplified_gps_baseband.
- On each rising edge of accum_int it acts as a Wishbone master and reads correlator status, the new_data flags and, when channel 0 has dumped, the six accumulators IE..QL.
- It commits each complete dump as one 7-word record into an internal FIFO, which the tracking CPU drains at its own pace.

---
 rtl/corr_dump_collector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/corr_dump_collector.sv
// Wishbone-mastering dump collector: on each accum_int rising edge reads baseband status,
// new_data and (if channel 0 dumped) six accumulators, committing 7-word records to a FIFO.
module corr_dump_collector #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          hw_rstn,
  input  logic                          accum_int,
  output logic [31:0]                   m_adr_o,
  input  logic [31:0]                   m_dat_i,
  output logic                          m_cyc_o,
  output logic                          m_stb_o,
  output logic                          m_we_o,
  output logic [3:0]                    m_sel_o,
  input  logic                          m_ack_i,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          dropped,
  output logic                          bus_err,
  input  logic                          clr_flags
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StRdStat, StRdNew, StCheck, StRdAcc, StGap, StCommit
  } state_e;

  state_e          r_state, r_next;
  logic            r_accum_d, r_pending;
  logic            r_cyc, r_stb;
  logic [31:0]     r_adr;
  logic [7:0]      r_status, r_new, r_seq;
  logic [2:0]      r_idx;
  logic [TW-1:0]   r_tmo;
  logic [AW-1:0]   r_wptr, r_wptr_s, r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_overrun, r_dropped, r_bus_err;
  logic [31:0]     r_mem [FIFO_DEPTH];

  logic            w_edge, w_ack, w_tmo, w_pop, w_commit, w_space_ok;
  logic            w_set_overrun, w_set_dropped, w_set_buserr;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [31:0]     w_mem_wdata;
  logic [LW-1:0]   w_free;

  always_comb begin
    w_edge        = accum_int & ~r_accum_d;
    w_ack         = m_ack_i & r_stb;
    w_tmo         = r_stb & ~m_ack_i & (r_tmo == TW'(ACK_TIMEOUT - 1));
    w_pop         = rd_en & (r_level != '0);
    w_commit      = (r_state == StCommit);
    w_free        = LW'(FIFO_DEPTH) - r_level;
    w_space_ok    = (w_free >= LW'(7));
    w_set_overrun = w_edge & (r_state != StIdle);
    w_set_dropped = (r_state == StCheck) & r_new[0] & ~w_space_ok;
    w_set_buserr  = w_tmo;
    w_mem_we      = ((r_state == StCheck) & r_new[0] & w_space_ok) |
                    ((r_state == StRdAcc) & w_ack);
    w_mem_addr    = (r_state == StCheck) ? r_wptr : r_wptr_s;
    w_mem_wdata   = (r_state == StCheck) ? {8'hA5, r_seq, r_status, r_new} : m_dat_i;
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      r_state   <= StIdle;
      r_next    <= StIdle;
      r_pending <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_adr     <= '0;
      r_status  <= '0;
      r_new     <= '0;
      r_seq     <= '0;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_wptr    <= '0;
      r_wptr_s  <= '0;
    end else begin
      if (w_set_overrun) r_pending <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_edge || r_pending) begin
            r_pending <= 1'b0;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_adr     <= BASE_ADDR + 32'h380;
            r_tmo     <= '0;
            r_state   <= StRdStat;
          end
        end
        StRdStat, StRdNew, StRdAcc: begin
          if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_state == StRdStat) begin
              r_status <= m_dat_i[7:0];
              r_next   <= StRdNew;
              r_state  <= StGap;
            end else if (r_state == StRdNew) begin
              // CHECK doubles as the idle cycle before the first accumulator read
              r_new   <= m_dat_i[7:0];
              r_state <= StCheck;
            end else begin
              r_wptr_s <= r_wptr_s + AW'(1);
              if (r_idx == 3'd5) begin
                r_state <= StCommit;
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_next  <= StRdAcc;
                r_state <= StGap;
              end
            end
          end else if (w_tmo) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        StGap: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_tmo   <= '0;
          r_state <= r_next;
          r_adr   <= (r_next == StRdNew) ? BASE_ADDR + 32'h384
                                         : BASE_ADDR + 32'h10 + {27'd0, r_idx, 2'b00};
        end
        StCheck: begin
          if (!r_new[0]) begin
            r_state <= StIdle;
          end else if (!w_space_ok) begin
            r_seq   <= r_seq + 8'd1;
            r_state <= StIdle;
          end else begin
            r_wptr_s <= r_wptr + AW'(1);
            r_idx    <= '0;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_tmo    <= '0;
            r_adr    <= BASE_ADDR + 32'h10;
            r_state  <= StRdAcc;
          end
        end
        StCommit: begin
          r_wptr  <= r_wptr_s;
          r_seq   <= r_seq + 8'd1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      r_accum_d <= 1'b0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_dropped <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_accum_d <= accum_int;
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + (w_commit ? LW'(7) : LW'(0)) - (w_pop ? LW'(1) : LW'(0));
      // A set in the same cycle as clr_flags wins
      if (w_set_overrun)  r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
      if (w_set_dropped)  r_dropped <= 1'b1;
      else if (clr_flags) r_dropped <= 1'b0;
      if (w_set_buserr)   r_bus_err <= 1'b1;
      else if (clr_flags) r_bus_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign m_adr_o = r_adr;
  assign m_cyc_o = r_cyc;
  assign m_stb_o = r_stb;
  assign m_we_o  = 1'b0;
  assign m_sel_o = 4'hf;
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = empty ? 32'd0 : r_mem[r_rptr];
  assign overrun = r_overrun;
  assign dropped = r_dropped;
  assign bus_err = r_bus_err;

endmodule
